// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: FSM states and the
// phase layout of START, bit slots and STOP.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK_A,
    ST_DATA,
    ST_ACK_D,
    ST_STOP,
    ST_DONE
  } state_e;

  localparam int unsigned START_PHASES = 2;
  localparam int unsigned BIT_PHASES   = 4;
  localparam int unsigned STOP_PHASES  = 3;

  // Bit slot: phases 0..1 SCL low, 2..3 SCL released; SDA sampled as phase 2 ends.
  localparam logic [1:0] PH_SCL_LOW_LAST = 2'd1;
  localparam logic [1:0] PH_SAMPLE       = 2'd2;
  localparam logic [1:0] PH_BIT_LAST     = 2'(BIT_PHASES - 1);
  localparam logic [1:0] PH_START_LAST   = 2'(START_PHASES - 1);
  localparam logic [1:0] PH_STOP_LAST    = 2'(STOP_PHASES - 1);
  localparam logic [2:0] BIT_LAST        = 3'd7;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase tick generator: one tick every CLK_DIV clocks, held at zero
// while clear_i is high.
module i2c_phase_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [7:0] CNT_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (clear_i || cnt_q == CNT_LAST) cnt_d = '0;
  end

  assign tick_o = !clear_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master (write or read) driving open-drain SCL/SDA enables,
// sequenced by quarter-phase ticks from i2c_phase_gen.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] adress,
  input  logic [7:0] i_data,
  input  logic       i_sda,
  output logic [7:0] o_data,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       o_scl,
  output logic       o_sda,
  output logic       o_scl_en,
  output logic       o_sda_en
);

  state_e     state_q, state_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, wdat_q, wdat_d, odata_q, odata_d;
  logic       rw_q, rw_d, nack_q, nack_d;
  logic       tick, clear, scl_pull, sda_pull, rd_data;

  // The accept cycle already counts towards START phase 0 (bus idle either way),
  // so done lands exactly N*CLK_DIV cycles after accept.
  assign clear = (state_q == ST_IDLE && !req) || state_q == ST_DONE;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (clear),
    .tick_o  (tick)
  );

  assign rd_data = (state_q == ST_DATA) && rw_q;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wdat_d   = wdat_q;
    odata_d  = odata_q;
    rw_d     = rw_q;
    nack_d   = nack_q;
    scl_pull = 1'b0;
    sda_pull = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          rw_d    = rw;
          wdat_d  = i_data;
          sh_d    = {adress, rw};
          nack_d  = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        sda_pull = (ph_q == PH_START_LAST);
        if (tick) begin
          if (ph_q == PH_START_LAST) begin
            ph_d    = '0;
            state_d = ST_ADDR;
          end else ph_d = ph_q + 2'd1;
        end
      end
      ST_ADDR, ST_DATA: begin
        scl_pull = (ph_q <= PH_SCL_LOW_LAST);
        sda_pull = !rd_data && !sh_q[7];
        if (tick) begin
          if (rd_data && ph_q == PH_SAMPLE) sh_d = {sh_q[6:0], i_sda};
          if (ph_q == PH_BIT_LAST) begin
            ph_d  = '0;
            bit_d = bit_q + 3'd1;
            if (!rd_data) sh_d = {sh_q[6:0], 1'b0};
            if (bit_q == BIT_LAST) state_d = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
          end else ph_d = ph_q + 2'd1;
        end
      end
      ST_ACK_A, ST_ACK_D: begin
        scl_pull = (ph_q <= PH_SCL_LOW_LAST);
        if (tick) begin
          // The read ACK_D slot is the master's own NACK and is not sampled.
          if (ph_q == PH_SAMPLE && (state_q == ST_ACK_A || !rw_q) && i_sda) nack_d = 1'b1;
          if (ph_q == PH_BIT_LAST) begin
            ph_d = '0;
            if (state_q == ST_ACK_A) begin
              state_d = nack_q ? ST_STOP : ST_DATA;
              sh_d    = wdat_q;
            end else state_d = ST_STOP;
          end else ph_d = ph_q + 2'd1;
        end
      end
      ST_STOP: begin
        scl_pull = (ph_q == 2'd0);
        sda_pull = (ph_q != PH_STOP_LAST);
        if (tick) begin
          if (ph_q == PH_STOP_LAST) begin
            ph_d    = '0;
            state_d = ST_DONE;
            if (rw_q && !nack_q) odata_d = sh_q;
          end else ph_d = ph_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      wdat_q  <= '0;
      odata_q <= '0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      wdat_q  <= wdat_d;
      odata_q <= odata_d;
      rw_q    <= rw_d;
      nack_q  <= nack_d;
    end
  end

  assign busy     = rst && ((state_q != ST_IDLE) || req);
  assign done     = (state_q == ST_DONE);
  assign nack     = nack_q;
  assign o_data   = odata_q;
  assign o_scl    = 1'b0;
  assign o_sda    = 1'b0;
  assign o_scl_en = scl_pull;
  assign o_sda_en = sda_pull;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: a CLK_DIV=4 and a CLK_DIV=2 instance
// share one bus-level slave model and monitor, selected by sel.
module tb_i2c_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req, rw, sel;
  logic [6:0] adress;
  logic [7:0] i_data;
  logic       i_sda, req4, req2, slave_pull;

  logic [7:0] o_data4, o_data2, o_data_m;
  logic busy4, done4, nack4, scl4, sda4, scl_en4, sda_en4;
  logic busy2, done2, nack2, scl2, sda2, scl_en2, sda_en2;
  logic busy_m, done_m, nack_m, scl_m, sda_m, scl_en_m, sda_en_m;

  assign req4 = req & ~sel;
  assign req2 = req & sel;
  assign o_data_m = sel ? o_data2 : o_data4;
  assign busy_m   = sel ? busy2   : busy4;
  assign done_m   = sel ? done2   : done4;
  assign nack_m   = sel ? nack2   : nack4;
  assign scl_m    = sel ? scl2    : scl4;
  assign sda_m    = sel ? sda2    : sda4;
  assign scl_en_m = sel ? scl_en2 : scl_en4;
  assign sda_en_m = sel ? sda_en2 : sda_en4;
  assign i_sda    = ~sda_en_m & ~slave_pull;

  i2c_master_ctrl #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .rw(rw), .adress(adress), .i_data(i_data),
    .i_sda(i_sda), .o_data(o_data4), .busy(busy4), .done(done4), .nack(nack4),
    .o_scl(scl4), .o_sda(sda4), .o_scl_en(scl_en4), .o_sda_en(sda_en4));

  i2c_master_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .rw(rw), .adress(adress), .i_data(i_data),
    .i_sda(i_sda), .o_data(o_data2), .busy(busy2), .done(done2), .nack(nack2),
    .o_scl(scl2), .o_sda(sda2), .o_scl_en(scl_en2), .o_sda_en(sda_en2));

  typedef struct {
    int unsigned cyc;
    logic        nack;
    logic [7:0]  odata;
    logic [7:0]  abyte;
    logic [7:0]  dbyte;
    logic        rw;
    int          nrise;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned last_acc;
  logic [7:0]  exp_odata = 8'h00;

  // slave configuration and bus monitor state
  logic       cfg_ack = 1'b0, cfg_rw = 1'b0;
  logic [7:0] cfg_rd = 8'h00;
  int         slot = -1, nrise = 0, nhi = 0, done_cnt = 0;
  logic [7:0] abits = 8'h00, dbits = 8'h00;
  logic       rd_rel = 1'b1, pscl = 1'b0, psda = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    slave_pull = 1'b0;
    forever begin
      @(negedge clk);
      if (done_m) done_cnt++;
      if (sda_en_m !== psda && !scl_en_m) begin
        if (sda_en_m) begin  // START: SDA pulled while SCL released
          slot = -1; nrise = 0; nhi = 0; abits = 8'h00; dbits = 8'h00;
          rd_rel = 1'b1; slave_pull = 1'b0;
        end
        nhi++;
      end
      if (scl_en_m && !pscl) begin
        slot++;
        if (slot == 8) slave_pull = cfg_ack;
        else if (slot >= 9 && slot <= 16) slave_pull = cfg_ack & cfg_rw & ~cfg_rd[3'(16 - slot)];
        else if (slot == 17) slave_pull = cfg_ack & ~cfg_rw;
        else slave_pull = 1'b0;
      end
      if (!scl_en_m && pscl) begin
        nrise++;
        if (slot >= 0 && slot <= 7) abits = {abits[6:0], i_sda};
        else if (slot >= 9 && slot <= 16) begin
          dbits  = {dbits[6:0], i_sda};
          rd_rel = rd_rel & ~sda_en_m;
        end else if (slot == 17) rd_rel = rd_rel & ~sda_en_m;
      end
      pscl = scl_en_m;
      psda = sda_en_m;
    end
  end

  task automatic push_exp(input int unsigned acc, input logic r, input logic [6:0] a,
                          input logic [7:0] d, input logic ack, input logic [7:0] rd,
                          input int unsigned cd);
    exp_t e;
    e.cyc = acc + (ack ? 77 : 41) * cd;
    e.nack = ~ack;
    if (r && ack) exp_odata = rd;
    e.odata = exp_odata;
    e.abyte = {a, r};
    e.dbyte = r ? rd : d;
    e.rw = r;
    e.nrise = ack ? 19 : 10;
    sb.push_back(e);
  endtask

  // Call at #1 after a posedge; leaves req low one cycle later.
  task automatic start_txn(input logic s, input logic r, input logic [6:0] a,
                           input logic [7:0] d, input logic ack, input logic [7:0] rd,
                           input logic push);
    sel = s; rw = r; adress = a; i_data = d;
    cfg_ack = ack; cfg_rw = r; cfg_rd = rd;
    req = 1'b1;
    last_acc = cyc;
    if (push) push_exp(last_acc, r, a, d, ack, rd, s ? 2 : 4);
    #1;
    checks++;
    if (busy_m !== 1'b1) begin errors++; $display("FAIL busy_accept: got %b want 1", busy_m); end
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (nack_m !== 1'b0) begin errors++; $display("FAIL nack_clear: got %b want 0", nack_m); end
  endtask

  task automatic wait_done(input int unsigned budget);
    exp_t e;
    bit seen = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_m) begin seen = 1'b1; break; end
    end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL sb_empty: got 0 entries want >0"); return; end
    e = sb.pop_front();
    if (!seen) begin errors++; $display("FAIL done_timeout: got none want cycle %0d", e.cyc); return; end
    checks++;
    if (cyc !== e.cyc) begin errors++; $display("FAIL done_cycle: got %0d want %0d", cyc, e.cyc); end
    checks++;
    if (nack_m !== e.nack) begin errors++; $display("FAIL nack: got %b want %b", nack_m, e.nack); end
    checks++;
    if (o_data_m !== e.odata) begin errors++; $display("FAIL o_data: got %h want %h", o_data_m, e.odata); end
    checks++;
    if (abits !== e.abyte) begin errors++; $display("FAIL addr_byte: got %h want %h", abits, e.abyte); end
    checks++;
    if (nrise !== e.nrise) begin errors++; $display("FAIL scl_pulses: got %0d want %0d", nrise, e.nrise); end
    checks++;
    if (nhi !== 2) begin errors++; $display("FAIL sda_while_scl_high: got %0d want 2", nhi); end
    checks++;
    if (busy_m !== 1'b1) begin errors++; $display("FAIL busy_done: got %b want 1", busy_m); end
    checks++;
    if ({scl_m, sda_m} !== 2'b00) begin errors++; $display("FAIL drive_vals: got %b want 00", {scl_m, sda_m}); end
    if (!e.nack) begin
      checks++;
      if (dbits !== e.dbyte) begin errors++; $display("FAIL data_byte: got %h want %h", dbits, e.dbyte); end
    end
    if (e.rw && !e.nack) begin
      checks++;
      if (rd_rel !== 1'b1) begin errors++; $display("FAIL read_sda_release: got %b want 1", rd_rel); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b1; rw = 1'b0; adress = '0; i_data = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({scl_en_m, sda_en_m, busy_m, done_m, nack_m} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got %b want 00000", s, {scl_en_m, sda_en_m, busy_m, done_m, nack_m});
      end
      checks++;
      if (o_data_m !== 8'h00) begin errors++; $display("FAIL reset_odata[%0d]: got %h want 00", s, o_data_m); end
    end
    sel = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    start_txn(1'b0, 1'b0, 7'h50, 8'hA5, 1'b1, 8'h00, 1'b1);
    wait_done(400);
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    start_txn(1'b0, 1'b1, 7'h50, 8'h00, 1'b1, 8'h3C, 1'b1);
    wait_done(400);
  endtask

  task automatic test_nack();
    @(posedge clk); #1;
    start_txn(1'b0, 1'b0, 7'h50, 8'h77, 1'b0, 8'h00, 1'b1);
    wait_done(400);
  endtask

  task automatic test_ignore_req();
    int d0;
    @(posedge clk); #1;
    start_txn(1'b0, 1'b0, 7'h2B, 8'h96, 1'b1, 8'h00, 1'b1);
    while (cyc < last_acc + 50) begin @(posedge clk); #1; end
    rw = 1'b1; adress = 7'h11; i_data = 8'h00; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    d0 = done_cnt;
    wait_done(400);
    repeat (40) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL one_done: got %0d want 1", done_cnt - d0); end
    checks++;
    if (busy_m !== 1'b0) begin errors++; $display("FAIL idle_after: got %b want 0", busy_m); end
  endtask

  task automatic test_midreset();
    bit hit = 1'b0;
    @(posedge clk); #1;
    start_txn(1'b0, 1'b0, 7'h50, 8'hE1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (slot == 12 && scl_en_m) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reach_data_bit3: got timeout want slot 12"); end
    checks++;
    if (sda_en_m !== 1'b1) begin errors++; $display("FAIL data_bit3_sda: got %b want 1", sda_en_m); end
    rst = 1'b0;
    #1;
    checks++;
    if ({scl_en_m, sda_en_m, busy_m, done_m, nack_m} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b want 00000", {scl_en_m, sda_en_m, busy_m, done_m, nack_m});
    end
    checks++;
    if (o_data_m !== 8'h00) begin errors++; $display("FAIL midreset_odata: got %h want 00", o_data_m); end
    exp_odata = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_txn(1'b0, 1'b0, 7'h63, 8'h0F, 1'b1, 8'h00, 1'b1);
    wait_done(400);
  endtask

  task automatic test_back_to_back();
    int d0;
    @(posedge clk); #1;
    sel = 1'b1; rw = 1'b0; adress = 7'h50; i_data = 8'h5A;
    cfg_ack = 1'b1; cfg_rw = 1'b0; cfg_rd = 8'h00;
    req = 1'b1;
    last_acc = cyc;
    for (int unsigned k = 0; k < 3; k++) push_exp(last_acc + k * 155, 1'b0, 7'h50, 8'h5A, 1'b1, 8'h00, 2);
    d0 = done_cnt;
    for (int k = 0; k < 3; k++) wait_done(400);
    req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_m !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_in_done: got %b want 0", busy_m); end
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_ignore_req();
    test_midreset();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_ctrl.md
I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCL quarter-phase; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  transaction request; sampled only in IDLE.
REQ-005 rw  input  1  0 = single-byte write, 1 = single-byte read; latched with req.
REQ-006 adress  input  7  target slave address; latched with req.
REQ-007 i_data  input  8  write byte; latched with req.
REQ-008 i_sda  input  1  sampled SDA bus level.
REQ-009 o_data  output  8  last byte read from slave.
REQ-010 busy  output  1  high from accept cycle until done cycle inclusive.
REQ-011 done  output  1  one-cycle pulse at transaction end.
REQ-012 nack  output  1  valid with done; 1 = slave did not acknowledge.
REQ-013 o_scl, o_sda  output  1 each  constant 0 (open-drain pull-down value).
REQ-014 o_scl_en, o_sda_en  output  1 each  1 = pull line low, 0 = release (bus pulled high).

Function
REQ-015 Phase tick every CLK_DIV clk cycles while busy; counter held at 0 in IDLE.
REQ-016 States: IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP, DONE.
REQ-017 IDLE: both lines released; req=1 -> latch rw/adress/i_data, busy=1, enter START next cycle.
REQ-018 req while busy is ignored; no queuing.
REQ-019 START, 2 phases: SCL/SDA released; then SDA pulled low with SCL released.
REQ-020 Bit slot = 4 phases: SCL low, low, released, released.
REQ-021 In a bit slot, master-driven SDA changes only at phase 0; i_sda is sampled at end of phase 2.
REQ-022 ADDR: 8 slots, MSB first: adress[6:0], then rw.
REQ-023 ACK_A: SDA released; sampled 1 -> nack=1, skip DATA/ACK_D, go to STOP.
REQ-024 DATA write: i_data MSB first.
REQ-025 DATA read: SDA released; o_data shifted MSB first from samples.
REQ-026 ACK_D write: SDA released; sampled 1 -> nack=1.
REQ-027 ACK_D read: master releases SDA (NACK, last byte); nack stays 0.
REQ-028 STOP, 3 phases: SCL low/SDA low; SCL released/SDA low; both released.
REQ-029 DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
REQ-030 Full transaction is 77 phases; done asserts exactly 77*CLK_DIV cycles after the accept cycle.
REQ-031 Address NACK is 41 phases; done asserts at 41*CLK_DIV cycles.
REQ-032 o_data updates only on completed reads; nack clears at next accept.
REQ-033 req asserted in the DONE cycle is not accepted; earliest accept is the following cycle.

Reset
REQ-034 rst=0 immediately forces: IDLE, phase counter 0, o_scl_en=0, o_sda_en=0, busy=0, done=0, nack=0, o_data=8'h00.
REQ-035 Reset mid-transaction releases the bus with no STOP generated; first req after rst=1 starts cleanly.

Structure
REQ-036 Package i2c_pkg holds the state enum, phase counts (START=2, BIT=4, STOP=3), and bit-slot phase indices.
REQ-037 Sub-module i2c_phase_gen (CLK_DIV counter, tick output, clear input) is instantiated once; all else is in one FSM plus shift register.

Verification
REQ-038 Write adress=7'h50, i_data=8'hA5, slave ACKs -> SDA bit sequence 0xA0 then 0xA5, done at cycle 308 (CLK_DIV=4), nack=0.
REQ-039 Read adress=7'h50, slave returns 8'h3C -> o_data=8'h3C, master ACK_D slot released, nack=0.
REQ-040 Write, no slave (SDA floats 1) -> nack=1, STOP follows ACK_A, done at cycle 164.
REQ-041 req pulsed at cycle 50 of an active transaction -> ignored; exactly one done.
REQ-042 rst=0 during DATA bit 3 -> same-cycle o_scl_en=o_sda_en=0, busy=0; next req completes normally.
REQ-043 CLK_DIV=2, back-to-back req held high -> transactions 154 cycles apart plus one idle cycle; SDA changes only while SCL is low, except START/STOP edges.
